// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared definitions for the cpu_sequencer slice.
//   - opcode constants of the supported instruction classes
//   - ALU operation codes driven on the sequencer's op output
//   - sequencer state enum
//   - decoded control bundle (cpu_seq_decode -> cpu_sequencer)
//   - registered datapath-control bundle driven by cpu_sequencer
package cpu_seq_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'h33;
  localparam logic [6:0] OPC_ITYPE  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  // Everything the FSM needs to know about one instruction word.
  typedef struct packed {
    logic       legal;      // opcode is one of the six supported classes
    logic       nop;        // all-zero word: clean halt
    logic       alu_src;
    logic [2:0] alu_op;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       uses_mem;   // EXEC continues into MEM
    logic       br_eq;      // branch taken when zero
    logic       br_ne;      // branch taken when !zero
  } ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic [2:0] op;
  } ctl_out_t;

  localparam ctl_out_t CTL_QUIET = '{
    reg_write: 1'b0,
    alu_src:   1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    mem2reg:   1'b0,
    op:        ALU_ADD
  };

endpackage

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: purely combinational opcode/funct decode.
// Ports:
//   instr [31:0] in  : instruction word to decode
//   ctrl         out : decoded control bundle (cpu_seq_pkg::ctrl_t)
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  always_comb begin
    opcode = instr[6:0];
    funct3 = instr[14:12];

    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.alu_src = 1'b1;
    ctrl.nop     = (instr == '0);

    case (opcode)
      OPC_RTYPE: begin
        ctrl.legal   = 1'b1;
        ctrl.alu_src = 1'b0;
        case (funct3)
          3'b000:  ctrl.alu_op = instr[30] ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl.alu_op = ALU_AND;
          3'b110:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OPC_ITYPE: begin
        ctrl.legal = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.legal    = 1'b1;
        ctrl.is_load  = 1'b1;
        ctrl.uses_mem = 1'b1;
      end
      OPC_STORE: begin
        ctrl.legal    = 1'b1;
        ctrl.is_store = 1'b1;
        ctrl.uses_mem = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.legal     = 1'b1;
        ctrl.is_branch = 1'b1;
        ctrl.alu_src   = 1'b0;
        ctrl.alu_op    = ALU_SUB;
        // Any other funct3 decodes as a never-taken branch.
        ctrl.br_eq     = (funct3 == F3_BEQ);
        ctrl.br_ne     = (funct3 == F3_BNE);
      end
      OPC_JAL: begin
        ctrl.legal   = 1'b1;
        ctrl.is_jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer
// (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT) with PC and retire counter.
// Optional feature macro: CPU_SEQ_PERF_EN -- enables the 32-bit retired
// counter and the MAX_RETIRE halt limit; without it retired reads 0.
// Parameters:
//   ENTRY_PC   : PC loaded at reset
//   MAX_RETIRE : retire count that forces HALT (0 = unlimited)
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : leave IDLE and begin fetching at PCin
//   ins               : instruction at PCin from the fetch stage
//   zero              : ALU zero flag, sampled in EXEC
//   branch, jTarget   : branch / jump targets from decode
//   PCin              : current program counter
//   RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op : datapath controls
//   halted, illegal   : in HALT; HALT caused by an unknown opcode
//   retired           : retired-instruction count
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [31:0] ENTRY_PC   = 32'h0000_0028,
  parameter int unsigned MAX_RETIRE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] branch,
  input  logic [31:0] jTarget,
  output logic [31:0] PCin,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic [2:0]  op,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

`ifdef CPU_SEQ_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [31:0] pc_q, pc_d;
  logic        pc_upd;
  logic        set_illegal;
  logic        halted_q, illegal_q;
  logic [31:0] retired_q;
  logic        limit_hit;
  logic        taken;
  logic [31:0] dec_word;
  ctrl_t       ctrl;
  ctl_out_t    ctl_q, ctl_d;

  // In FETCH the word is decoded straight from ins so that the controls
  // registered on entry to DECODE are already valid in that cycle.
  assign dec_word = (state_q == FETCH) ? ins : ir_q;

  cpu_seq_decode u_decode (
    .instr (dec_word),
    .ctrl  (ctrl)
  );

  assign limit_hit = PERF_EN && (MAX_RETIRE != 0) &&
                     ((retired_q + 32'd1) == MAX_RETIRE);

  assign taken = (ctrl.br_eq && zero) || (ctrl.br_ne && !zero);

  // Next state, PC update and retire decision.
  always_comb begin
    state_d     = state_q;
    pc_upd      = 1'b0;
    pc_d        = pc_q + 32'd4;
    set_illegal = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (ctrl.nop) begin
          state_d = HALT;
        end else if (!ctrl.legal) begin
          state_d     = HALT;
          set_illegal = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ctrl.is_branch) begin
          pc_upd  = 1'b1;
          if (taken) pc_d = branch;
          state_d = limit_hit ? HALT : FETCH;
        end else if (ctrl.uses_mem) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (ctrl.is_load) begin
          state_d = WB;
        end else begin
          pc_upd  = 1'b1;
          state_d = limit_hit ? HALT : FETCH;
        end
      end
      WB: begin
        pc_upd  = 1'b1;
        if (ctrl.is_jump) pc_d = jTarget;
        state_d = limit_hit ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Controls for the state being entered, so the outputs can be registered.
  always_comb begin
    ctl_d = CTL_QUIET;
    case (state_d)
      DECODE, EXEC: begin
        ctl_d.alu_src = ctrl.alu_src;
        ctl_d.op      = ctrl.alu_op;
      end
      MEM: begin
        ctl_d.alu_src   = ctrl.alu_src;
        ctl_d.op        = ctrl.alu_op;
        ctl_d.mem_read  = ctrl.is_load;
        ctl_d.mem_write = ctrl.is_store;
        ctl_d.mem2reg   = ctrl.is_load;
      end
      WB: begin
        ctl_d.alu_src   = ctrl.alu_src;
        ctl_d.op        = ctrl.alu_op;
        ctl_d.reg_write = 1'b1;
        ctl_d.mem2reg   = ctrl.is_load;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= ENTRY_PC;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      ctl_q     <= CTL_QUIET;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      halted_q <= (state_d == HALT);
      if (set_illegal) illegal_q <= 1'b1;
      if (state_q == FETCH) ir_q <= ins;
      if (pc_upd) begin
        pc_q <= pc_d;
`ifdef CPU_SEQ_PERF_EN
        retired_q <= retired_q + 32'd1;
`endif
      end
    end
  end

  assign PCin     = pc_q;
  assign RegWrite = ctl_q.reg_write;
  assign ALUSrc   = ctl_q.alu_src;
  assign MemRead  = ctl_q.mem_read;
  assign MemWrite = ctl_q.mem_write;
  assign Mem2Reg  = ctl_q.mem2reg;
  assign op       = ctl_q.op;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule
